prog_freq_divider: RTL and testbench
====================================

PROG_FREQ_DIVIDER -- requirements
Module: prog_freq_divider

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH, 8, width of divide-value and counter
  INIT_DIV, 1, divide value loaded at reset (must fit WIDTH)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  input  1  single clock, all state on rising edge
  reset  input  1  synchronous, active-high reset
  en  input  1  count enable (generalised T input)
  mode  input  1  0 = toggle (square-wave q), 1 = pulse (q = tick)
  div_load  input  1  load request for div_val
  div_val  input  WIDTH  requested terminal count
  q  output  1  divided output, registered
  q_bar  output  1  always ~q
  tick  output  1  one-cycle pulse per completed period, registered
  count  output  WIDTH  current counter value
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high, named clk and reset.

Function
REQ-004 Internal state SHALL be: counter cnt, active terminal count div_r, pending value div_p, pending flag pend.
REQ-005 With en=1 and cnt!=div_r, cnt SHALL increment by 1 per edge; tick SHALL be 0 next cycle.
REQ-006 With en=1 and cnt==div_r (wrap), cnt SHALL become 0, tick SHALL be 1 for exactly the next cycle.
REQ-007 In mode 0, q SHALL invert on every wrap edge and hold otherwise; q period = 2*(div_r+1) cycles, tick period = div_r+1.
REQ-008 In mode 1, q SHALL equal the registered tick value (one-cycle high per period).
REQ-009 Mode change SHALL take effect at the next edge; the counter SHALL NOT restart on mode change.
REQ-010 div_r=0 with en=1 SHALL give q toggling every edge (clk/2) and tick constantly 1 -- the T flip-flop special case.
REQ-011 With en=0, cnt and q SHALL hold and tick SHALL be 0.
REQ-012 div_load with en=0 SHALL write div_val into div_r at that edge and clear pend; cnt unchanged.
REQ-013 div_load with en=1 on a non-wrap cycle SHALL store div_val in div_p and set pend; the current period completes with the old div_r.
REQ-014 On a wrap edge with pend=1 and no div_load, div_r SHALL take div_p and pend SHALL clear.
REQ-015 div_load on the wrap edge itself SHALL write div_val directly into div_r (overriding any pending value) and clear pend.
REQ-016 A second div_load before wrap SHALL overwrite div_p (last request wins).
REQ-017 If div_r is written (REQ-012) below the held cnt, the next enabled edge SHALL treat cnt>div_r as wrap.
REQ-018 q_bar SHALL equal ~q in every cycle, including reset.

Reset
REQ-019 On an edge with reset=1: cnt=0, q=0, q_bar=1, tick=0, div_r=INIT_DIV, div_p=0, pend=0; reset SHALL override en, div_load and mode.
REQ-020 Reset asserted mid-period SHALL discard any pending load and restart the period from cnt=0 after release.

Structure
REQ-021 Mode encodings (MODE_TOGGLE=0, MODE_PULSE=1) SHALL live in the shared project constants package/header.
REQ-022 The block SHALL be a single flat module; no sub-module is required.

Verification
REQ-023 Bench SHALL cover:
  reset held 2 cycles -> q=0, q_bar=1, tick=0, count=0, div_r=INIT_DIV.
  div_val=0 loaded (en=0), then en=1 mode 0 -> q toggles every edge, tick=1 every cycle.
  div_val=3, en=1, mode 0 -> count 0,1,2,3,0..., q period 8 cycles, tick every 4th cycle.
  div=3, load div_val=1 at count=2 -> counts 3,0 then period 2 (0,1,0,1), q period 4.
  mode 1, div=4 -> q high 1 cycle in 5, q_bar its complement; en=0 mid-period freezes count, tick=0.
  reset at count=2 with pend=1, q=1 -> next edge all REQ-019 values, pending value never applied.

Source files
------------

// File: rtl/prog_freq_divider_pkg.sv
// Shared constants for the programmable frequency divider.
// Output-mode encodings are kept here so other blocks decode them the same way.
package prog_freq_divider_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

endpackage

// File: rtl/prog_freq_divider.sv
// Programmable divider: counts 0..div_r, pulses tick on wrap, and drives q as a
// square wave (toggle mode) or as a copy of tick (pulse mode).
module prog_freq_divider
  import prog_freq_divider_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned INIT_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  output logic             q,
  output logic             q_bar,
  output logic             tick,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] INIT_DIV_W = WIDTH'(INIT_DIV);

  mode_e            mode_sel;
  logic [WIDTH-1:0] cnt,   cnt_nx;
  logic [WIDTH-1:0] div_r, div_r_nx;
  logic [WIDTH-1:0] div_p, div_p_nx;
  logic             pend,  pend_nx;
  logic             q_r,   q_nx;
  logic             tick_r, tick_nx;
  logic             wrap;

  assign mode_sel = mode_e'(mode);

  // >= rather than == so a divide value lowered below a held count still wraps.
  assign wrap = en && (cnt >= div_r);

  always_comb begin
    cnt_nx   = cnt;
    div_r_nx = div_r;
    div_p_nx = div_p;
    pend_nx  = pend;
    q_nx     = q_r;
    tick_nx  = 1'b0;

    if (en) begin
      if (wrap) begin
        cnt_nx  = '0;
        tick_nx = 1'b1;
      end else begin
        cnt_nx  = cnt + 1'b1;
      end
    end

    unique case (mode_sel)
      MODE_TOGGLE: q_nx = q_r ^ wrap;
      MODE_PULSE:  q_nx = wrap;
      default:     q_nx = q_r;
    endcase

    // A direct write wins whenever no period is in flight (idle or on the wrap
    // edge itself); otherwise the request is parked until the period ends.
    if (div_load) begin
      if (!en || wrap) begin
        div_r_nx = div_val;
        pend_nx  = 1'b0;
      end else begin
        div_p_nx = div_val;
        pend_nx  = 1'b1;
      end
    end else if (wrap && pend) begin
      div_r_nx = div_p;
      pend_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      div_r  <= INIT_DIV_W;
      div_p  <= '0;
      pend   <= 1'b0;
      q_r    <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      cnt    <= cnt_nx;
      div_r  <= div_r_nx;
      div_p  <= div_p_nx;
      pend   <= pend_nx;
      q_r    <= q_nx;
      tick_r <= tick_nx;
    end
  end

  assign q     = q_r;
  assign q_bar = ~q_r;
  assign tick  = tick_r;
  assign count = cnt;

endmodule

// File: tb/tb_prog_freq_divider.sv
// Self-checking bench for prog_freq_divider: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a model.
module tb_prog_freq_divider;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned INIT_DIV = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic             mode = 1'b0;
  logic             div_load = 1'b0;
  logic [WIDTH-1:0] div_val = '0;
  logic             q, q_bar, tick;
  logic [WIDTH-1:0] count;

  int errors = 0;
  int checks = 0;

  prog_freq_divider #(.WIDTH(WIDTH), .INIT_DIV(INIT_DIV)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .div_load(div_load), .div_val(div_val),
    .q(q), .q_bar(q_bar), .tick(tick), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: period bookkeeping with plain integers.
  int m_cnt, m_div, m_dp;
  bit m_pend, m_q, m_tick, m_valid = 1'b0;

  always @(posedge clk) begin : model
    bit done;
    if (reset) begin
      m_cnt = 0; m_div = INIT_DIV; m_dp = 0; m_pend = 0;
      m_q = 0; m_tick = 0; m_valid = 1;
    end else if (m_valid) begin
      done   = en && (m_cnt >= m_div);
      m_tick = done;
      if (mode) m_q = done;
      else if (done) m_q = !m_q;
      if (done) m_cnt = 0;
      else if (en) m_cnt = m_cnt + 1;
      if (div_load) begin
        if (!en || done) begin m_div = int'(div_val); m_pend = 0; end
        else begin m_dp = int'(div_val); m_pend = 1; end
      end else if (done && m_pend) begin
        m_div = m_dp; m_pend = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (m_valid) begin
      chk("count", 32'(count), 32'(m_cnt));
      chk("q",     32'(q),     32'(m_q));
      chk("q_bar", 32'(q_bar), 32'(!m_q));
      chk("tick",  32'(tick),  32'(m_tick));
    end
  end

  task automatic cyc(input logic r, input logic e, input logic m,
                     input logic l, input logic [WIDTH-1:0] v);
    reset = r; en = e; mode = m; div_load = l; div_val = v;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input int c, input logic eq, input logic et);
    chk({name, ".count"}, 32'(count), 32'(c));
    chk({name, ".q"},     32'(q),     32'(eq));
    chk({name, ".q_bar"}, 32'(q_bar), 32'(!eq));
    chk({name, ".tick"},  32'(tick),  32'(et));
  endtask

  initial begin
    int    exp_c[8];
    logic  exp_q[8];
    // Reset held two cycles.
    cyc(1, 1, 1, 1, 8'd9);
    cyc(1, 1, 0, 1, 8'd9);
    lit("reset", 0, 0, 0);

    // INIT_DIV=2 after reset: 1,2,0 with tick on the wrap.
    cyc(0, 1, 0, 0, 0); lit("init1", 1, 0, 0);
    cyc(0, 1, 0, 0, 0); lit("init2", 2, 0, 0);
    cyc(0, 1, 0, 0, 0); lit("init0", 0, 1, 1);

    // Divide by 1 (div=0): q toggles every edge, tick stays high.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 8'd0); lit("ld0", 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 0);
      lit("tff", 0, (i % 2 == 0), 1);
    end

    // div=3 toggle mode: count 1,2,3,0,..., q period 8.
    exp_c = '{1, 2, 3, 0, 1, 2, 3, 0};
    exp_q = '{0, 0, 0, 1, 1, 1, 1, 0};
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 8'd3);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, 0);
      lit("div3", exp_c[i], exp_q[i], exp_c[i] == 0);
    end

    // Load 1 at count=2: old period finishes (3,0), then period 2.
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    chk("pre_load.count", 32'(count), 32'd2);
    exp_c = '{3, 0, 1, 0, 1, 0, 1, 0};
    exp_q = '{0, 1, 1, 0, 0, 1, 1, 0};
    cyc(0, 1, 0, 1, 8'd1); lit("pend", exp_c[0], exp_q[0], 0);
    for (int i = 1; i < 8; i++) begin
      cyc(0, 1, 0, 0, 0);
      lit("div1", exp_c[i], exp_q[i], exp_c[i] == 0);
    end

    // Pulse mode, div=4: q high one cycle in five; en=0 freezes.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 8'd4);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1, 1, 0, 0);
      lit("pulse", i % 5, (i % 5 == 0), (i % 5 == 0));
    end
    cyc(0, 1, 1, 0, 0); cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0); lit("hold", 2, 0, 0);
    cyc(0, 0, 1, 0, 0); lit("hold", 2, 0, 0);
    cyc(0, 1, 1, 0, 0); lit("resume", 3, 0, 0);

    // Divide value lowered below a held count wraps on the next enabled edge.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 8'd5);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 8'd1); lit("lower", 4, 0, 0);
    cyc(0, 1, 0, 0, 0);    lit("lowerwrap", 0, 1, 1);

    // Reset with a pending load and q=1: pending value must be discarded.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 8'd3);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 8'd1);
    cyc(0, 1, 0, 0, 0);
    lit("prerst", 2, 1, 0);
    cyc(1, 1, 0, 0, 0); lit("midrst", 0, 0, 0);
    cyc(0, 1, 0, 0, 0); lit("post1", 1, 0, 0);
    cyc(0, 1, 0, 0, 0); lit("post2", 2, 0, 0);
    cyc(0, 1, 0, 0, 0); lit("post0", 0, 1, 1);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      logic [WIDTH-1:0] v;
      v = ($urandom_range(0, 15) == 0) ? WIDTH'($urandom_range(0, 40))
                                       : WIDTH'($urandom_range(0, 6));
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 3) != 0,
          ($urandom_range(0, 15) == 0) ? ~mode : mode,
          $urandom_range(0, 7) == 0,
          v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
